// File: rtl/e203_lp_pkg.sv
// ---------------------------------------------------------------------------
// e203_lp_pkg
// Shared types and widths for the E203 low-power sequencer.
//   lp_state_e    : 2-bit sequencer state (RUN/DRAIN/SLEEP/WAKE)
//   LP_DRAIN_CW   : drain timeout counter width
//   LP_WAKE_CW    : wake settle counter width
//   LP_SLEEP_CW   : sleep-cycle performance counter width
//   lp_all_idle() : true when every drained unit reports idle
// ---------------------------------------------------------------------------
package e203_lp_pkg;

  typedef enum logic [1:0] {
    LP_RUN   = 2'd0,
    LP_DRAIN = 2'd1,
    LP_SLEEP = 2'd2,
    LP_WAKE  = 2'd3
  } lp_state_e;

  localparam int LP_DRAIN_CW = 8;
  localparam int LP_WAKE_CW  = 4;
  localparam int LP_SLEEP_CW = 16;

  function automatic logic lp_all_idle(input logic exu, input logic lsu, input logic biu);
    return exu & lsu & biu;
  endfunction

endpackage

// File: rtl/e203_lp_satcnt.sv
// ---------------------------------------------------------------------------
// e203_lp_satcnt
// Saturating up-counter with synchronous clear (clear beats increment).
//   clk   in  : clock
//   rst_n in  : asynchronous active-low reset
//   inc   in  : count up by one this cycle (held at all-ones once reached)
//   clr   in  : return to zero this cycle
//   cnt   out : registered count
// ---------------------------------------------------------------------------
module e203_lp_satcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // Count register: clear first, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {W{1'b0}};
    end else if (clr) begin
      cnt <= {W{1'b0}};
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/e203_lp_seq.sv
// ---------------------------------------------------------------------------
// e203_lp_seq
// Low-power sequencer: drains EXU/LSU/BIU on a WFI request, asserts core_wfi
// to gate the IFU clock, and on wake holds off sleep for a settle window.
//   clk, rst_n          : always-on clock, asynchronous active-low reset
//   wfi_req             : level WFI request from commit
//   wake_evt, dbg_mode  : wake sources; both block and end sleep
//   exu/lsu/biu_idle    : unit idle indications sampled during DRAIN
//   sleep_cnt_clr       : clears sleep_cycles
//   core_wfi            : WFI toward the clock controller
//   wfi_ack/wfi_abort   : one-cycle pulses for sleep entry / rejection
//   wake_done           : one-cycle pulse on return to RUN
//   lp_state            : current state for debug
//   sleep_cycles        : saturating SLEEP cycle count
// ---------------------------------------------------------------------------
module e203_lp_seq
  import e203_lp_pkg::*;
#(
  parameter int DRAIN_TMO = 255,
  parameter int WAKE_DLY  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wfi_req,
  input  logic        wake_evt,
  input  logic        dbg_mode,
  input  logic        exu_idle,
  input  logic        lsu_idle,
  input  logic        biu_idle,
  input  logic        sleep_cnt_clr,
  output logic        core_wfi,
  output logic        wfi_ack,
  output logic        wfi_abort,
  output logic        wake_done,
  output logic [1:0]  lp_state,
  output logic [15:0] sleep_cycles
);

  localparam logic [LP_DRAIN_CW-1:0] DRAIN_LAST = LP_DRAIN_CW'(DRAIN_TMO - 1);
  localparam logic [LP_WAKE_CW-1:0]  WAKE_LOAD  = LP_WAKE_CW'(WAKE_DLY - 1);

  lp_state_e              r_state;
  lp_state_e              w_next_state;
  logic [LP_DRAIN_CW-1:0] r_drain_cnt;
  logic [LP_DRAIN_CW-1:0] w_drain_cnt;
  logic [LP_WAKE_CW-1:0]  r_wake_cnt;
  logic [LP_WAKE_CW-1:0]  w_wake_cnt;
  logic                   w_ack;
  logic                   w_abort;
  logic                   w_done;
  logic                   w_wake_src;
  logic                   r_core_wfi;
  logic                   r_wfi_ack;
  logic                   r_wfi_abort;
  logic                   r_wake_done;

  assign w_wake_src = wake_evt | dbg_mode;

  // Next-state, counter and pulse decode.
  always_comb begin
    w_next_state = r_state;
    w_drain_cnt  = r_drain_cnt;
    w_wake_cnt   = r_wake_cnt;
    w_ack        = 1'b0;
    w_abort      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      LP_RUN: begin
        if (wfi_req && w_wake_src) begin
          w_abort = 1'b1;
        end else if (wfi_req) begin
          w_next_state = LP_DRAIN;
          w_drain_cnt  = {LP_DRAIN_CW{1'b0}};
        end else begin
          w_next_state = LP_RUN;
        end
      end
      LP_DRAIN: begin
        // A wake in the same cycle as all-idle must win, so it is tested first.
        if (w_wake_src || !wfi_req) begin
          w_next_state = LP_RUN;
          w_abort      = 1'b1;
        end else if (lp_all_idle(exu_idle, lsu_idle, biu_idle)) begin
          w_next_state = LP_SLEEP;
          w_ack        = 1'b1;
        end else if (r_drain_cnt == DRAIN_LAST) begin
          w_next_state = LP_RUN;
          w_abort      = 1'b1;
        end else begin
          w_drain_cnt = r_drain_cnt + {{(LP_DRAIN_CW-1){1'b0}}, 1'b1};
        end
      end
      LP_SLEEP: begin
        if (w_wake_src) begin
          w_next_state = LP_WAKE;
          w_wake_cnt   = WAKE_LOAD;
        end else begin
          w_next_state = LP_SLEEP;
        end
      end
      LP_WAKE: begin
        // Requests and wake sources are deliberately ignored while settling.
        if (r_wake_cnt == {LP_WAKE_CW{1'b0}}) begin
          w_next_state = LP_RUN;
          w_done       = 1'b1;
        end else begin
          w_wake_cnt = r_wake_cnt - {{(LP_WAKE_CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_next_state = LP_RUN;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LP_RUN;
      r_drain_cnt <= {LP_DRAIN_CW{1'b0}};
      r_wake_cnt  <= {LP_WAKE_CW{1'b0}};
      r_core_wfi  <= 1'b0;
      r_wfi_ack   <= 1'b0;
      r_wfi_abort <= 1'b0;
      r_wake_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_drain_cnt;
      r_wake_cnt  <= w_wake_cnt;
      r_core_wfi  <= (w_next_state == LP_SLEEP);
      r_wfi_ack   <= w_ack;
      r_wfi_abort <= w_abort;
      r_wake_done <= w_done;
    end
  end

  e203_lp_satcnt #(.W(LP_SLEEP_CW)) u_sleep_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (r_state == LP_SLEEP),
    .clr   (sleep_cnt_clr),
    .cnt   (sleep_cycles)
  );

  assign core_wfi  = r_core_wfi;
  assign wfi_ack   = r_wfi_ack;
  assign wfi_abort = r_wfi_abort;
  assign wake_done = r_wake_done;
  assign lp_state  = r_state;

endmodule

// File: tb/tb_e203_lp_seq.sv
// ---------------------------------------------------------------------------
// tb_e203_lp_seq
// Self-checking bench for e203_lp_seq (DRAIN_TMO=4, WAKE_DLY=2): a table of
// directed vectors, hand-written corner sequences and randomized traffic,
// all compared against a behavioural model kept in the bench.
// ---------------------------------------------------------------------------
module tb_e203_lp_seq;

  localparam int TMO  = 4;
  localparam int WDLY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wfi_req = 1'b0, wake_evt = 1'b0, dbg_mode = 1'b0;
  logic        exu_idle = 1'b0, lsu_idle = 1'b0, biu_idle = 1'b0;
  logic        sleep_cnt_clr = 1'b0;
  logic        core_wfi, wfi_ack, wfi_abort, wake_done;
  logic [1:0]  lp_state;
  logic [15:0] sleep_cycles;

  always #5 clk = ~clk;

  e203_lp_seq #(.DRAIN_TMO(TMO), .WAKE_DLY(WDLY)) dut (
    .clk(clk), .rst_n(rst_n), .wfi_req(wfi_req), .wake_evt(wake_evt),
    .dbg_mode(dbg_mode), .exu_idle(exu_idle), .lsu_idle(lsu_idle),
    .biu_idle(biu_idle), .sleep_cnt_clr(sleep_cnt_clr), .core_wfi(core_wfi),
    .wfi_ack(wfi_ack), .wfi_abort(wfi_abort), .wake_done(wake_done),
    .lp_state(lp_state), .sleep_cycles(sleep_cycles)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: mode 0=RUN 1=DRAIN 2=SLEEP 3=WAKE.
  int m_mode, m_drain_age, m_wake_left, m_slept;
  bit m_cwfi, m_ack, m_abort, m_done;

  typedef struct packed {
    logic req, wake, dbg, exu, lsu, biu, clr;
    logic [1:0] st;
    logic cwfi, ack, abt, done;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic req, logic wake, logic dbg, logic exu, logic lsu,
                              logic biu, logic clr, logic [1:0] st, logic cwfi,
                              logic ack, logic abt, logic done, logic [15:0] sc);
    vec_t v;
    v = {req, wake, dbg, exu, lsu, biu, clr, st, cwfi, ack, abt, done, sc};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] dut_vec();
    return {lp_state, core_wfi, wfi_ack, wfi_abort, wake_done, sleep_cycles};
  endfunction

  function automatic logic [21:0] model_vec();
    return {2'(m_mode), m_cwfi, m_ack, m_abort, m_done, 16'(m_slept)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_drain_age = 0; m_wake_left = 0; m_slept = 0;
    m_cwfi = 1'b0; m_ack = 1'b0; m_abort = 1'b0; m_done = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit wk;
    wk = wake_evt | dbg_mode;
    m_ack = 1'b0; m_abort = 1'b0; m_done = 1'b0;
    if (sleep_cnt_clr) m_slept = 0;
    else if (m_mode == 2 && m_slept < 65535) m_slept = m_slept + 1;
    case (m_mode)
      0: if (wfi_req) begin
           if (wk) m_abort = 1'b1;
           else begin m_mode = 1; m_drain_age = 1; end
         end
      1: if (wk || !wfi_req) begin m_mode = 0; m_abort = 1'b1; end
         else if (exu_idle && lsu_idle && biu_idle) begin m_mode = 2; m_ack = 1'b1; end
         else if (m_drain_age == TMO) begin m_mode = 0; m_abort = 1'b1; end
         else m_drain_age = m_drain_age + 1;
      2: if (wk) begin m_mode = 3; m_wake_left = WDLY; end
      default: if (m_wake_left == 1) begin m_mode = 0; m_done = 1'b1; end
               else m_wake_left = m_wake_left - 1;
    endcase
    m_cwfi = (m_mode == 2);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic set_in(logic req, logic wake, logic dbg, logic exu, logic lsu,
                        logic biu, logic clr);
    wfi_req = req; wake_evt = wake; dbg_mode = dbg;
    exu_idle = exu; lsu_idle = lsu; biu_idle = biu; sleep_cnt_clr = clr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_state", 32'(dut_vec()), 32'd0);
  endtask

  initial begin
    //              req wk dbg exu lsu biu clr  st  cwfi ack abt done sc
    tbl[0]  = mk(1, 0, 0, 1, 1, 1, 0, 2'd1, 0, 0, 0, 0, 16'd0);
    tbl[1]  = mk(1, 0, 0, 1, 1, 1, 0, 2'd2, 1, 1, 0, 0, 16'd0);
    tbl[2]  = mk(0, 0, 0, 1, 1, 1, 0, 2'd2, 1, 0, 0, 0, 16'd1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 1, 0, 0, 0, 16'd2);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 2'd3, 0, 0, 0, 0, 16'd3);
    tbl[5]  = mk(1, 0, 0, 1, 1, 1, 0, 2'd3, 0, 0, 0, 0, 16'd3);
    tbl[6]  = mk(0, 0, 0, 1, 1, 1, 0, 2'd0, 0, 0, 0, 1, 16'd3);
    tbl[7]  = mk(0, 0, 0, 1, 1, 1, 0, 2'd0, 0, 0, 0, 0, 16'd3);
    tbl[8]  = mk(1, 0, 1, 1, 1, 1, 0, 2'd0, 0, 0, 1, 0, 16'd3);
    tbl[9]  = mk(1, 0, 1, 1, 1, 1, 0, 2'd0, 0, 0, 1, 0, 16'd3);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 16'd3);
    tbl[11] = mk(1, 1, 0, 1, 1, 1, 0, 2'd0, 0, 0, 1, 0, 16'd3);
    tbl[12] = mk(1, 0, 0, 1, 0, 1, 0, 2'd1, 0, 0, 0, 0, 16'd3);
    tbl[13] = mk(0, 0, 0, 1, 0, 1, 0, 2'd0, 0, 0, 1, 0, 16'd3);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 16'd0);

    // Directed table.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].req, tbl[i].wake, tbl[i].dbg, tbl[i].exu, tbl[i].lsu,
             tbl[i].biu, tbl[i].clr);
      cycle();
      chk($sformatf("tbl[%0d]", i), 32'(dut_vec()),
          32'({tbl[i].st, tbl[i].cwfi, tbl[i].ack, tbl[i].abt, tbl[i].done, tbl[i].sc}));
    end

    // Drain timeout: request at cycle 0, DRAIN for cycles 1..4, RUN+abort at 5.
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= TMO + 1; k++) begin
      cycle();
      chk("tmo_state", 32'(lp_state), (k <= TMO) ? 32'd1 : 32'd0);
      chk("tmo_abort", 32'(wfi_abort), (k == TMO + 1) ? 32'd1 : 32'd0);
      chk("tmo_cwfi", 32'(core_wfi), 32'd0);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle();

    // Saturation, clear, then asynchronous reset while asleep.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle();
    cycle();
    wfi_req = 1'b0;
    for (int n = 0; n < 65540; n++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (n % 4096 == 0 || n > 65530) chk("sat_model", 32'(dut_vec()), 32'(model_vec()));
    end
    chk("sat_hold", 32'(sleep_cycles), 32'h0000FFFF);
    chk("sat_cwfi", 32'(core_wfi), 32'd1);
    sleep_cnt_clr = 1'b1;
    cycle();
    chk("clr_zero", 32'(sleep_cycles), 32'd0);
    sleep_cnt_clr = 1'b0;
    cycle();
    chk("clr_recount", 32'(sleep_cycles), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 32'(dut_vec()), 32'd0);
    model_reset();
    @(negedge clk);
    chk("rst_no_done", 32'(wake_done), 32'd0);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(99) < 75, $urandom_range(99) < 8, $urandom_range(99) < 4,
             $urandom_range(99) < 75, $urandom_range(99) < 75, $urandom_range(99) < 75,
             $urandom_range(99) < 3);
      cycle();
      if ((32'(wfi_ack) + 32'(wfi_abort) + 32'(wake_done)) > 32'd1)
        chk("pulse_excl", {wfi_ack, wfi_abort, wake_done}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e203_lp_seq.md
# e203_lp_seq

Low-power sequencer for the E203 core. It accepts the commit stage's WFI request, drains the EXU/LSU/BIU until they are idle, and then asserts `core_wfi` toward the clock controller so the IFU clock is gated. On a wake event it releases `core_wfi` and holds off further sleep for a settle window. It sits between the commit/CSR logic and the clock-control block, and keeps a saturating sleep-cycle counter for performance CSRs.

## Interface
- `DRAIN_TMO`, default 255: maximum number of DRAIN cycles before the request is aborted; range 1..255.
- `WAKE_DLY`, default 2: length of the WAKE settle window in cycles; range 1..15.
- `clk` in 1: core clock, always-on domain.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `wfi_req` in 1: level request from commit; held until `wfi_ack` or `wfi_abort`.
- `wake_evt` in 1: pending interrupt or external wake.
- `dbg_mode` in 1: debug mode active; blocks and ends sleep.
- `exu_idle` in 1: EXU idle.
- `lsu_idle` in 1: LSU idle.
- `biu_idle` in 1: BIU idle.
- `sleep_cnt_clr` in 1: clears `sleep_cycles`.
- `core_wfi` out 1: drives the clock controller's WFI input.
- `wfi_ack` out 1: one-cycle pulse marking sleep entry.
- `wfi_abort` out 1: one-cycle pulse marking a rejected or aborted request.
- `wake_done` out 1: one-cycle pulse marking return to RUN.
- `lp_state` out 2: current state, for debug visibility.
- `sleep_cycles` out 16: saturating count of SLEEP cycles.

## Operation
- All outputs are registered. Reset values: every output is 0 and the state is RUN.
- States and encodings: RUN = 0, DRAIN = 1, SLEEP = 2, WAKE = 3.
- RUN:
  - `wfi_req & ~wake_evt & ~dbg_mode` -> go to DRAIN and clear the drain counter.
  - `wfi_req & (wake_evt | dbg_mode)` -> stay in RUN and pulse `wfi_abort`.
- DRAIN, evaluated in priority order:
  1. `wake_evt | dbg_mode | ~wfi_req` -> go to RUN and pulse `wfi_abort`.
  2. `exu_idle & lsu_idle & biu_idle` in the same cycle -> go to SLEEP and pulse `wfi_ack`.
  3. Drain counter equals `DRAIN_TMO-1` -> go to RUN and pulse `wfi_abort`.
  4. Otherwise the drain counter increments.
- SLEEP:
  - `core_wfi` = 1 and `sleep_cycles` increments every cycle.
  - `wake_evt | dbg_mode` -> go to WAKE and load the wake counter with `WAKE_DLY-1`.
- WAKE:
  - `core_wfi` = 0 and `wfi_req` is ignored.
  - The wake counter decrements each cycle.
  - At 0 -> go to RUN and pulse `wake_done`.
- `sleep_cycles` saturates at 0xFFFF. `sleep_cnt_clr` takes priority over increment in the same cycle.
- Drain counter: 8 bits. Wake counter: 4 bits. Neither wraps: both are reloaded on state entry.

## Timing
- `wfi_req` seen in RUN at cycle t -> state is DRAIN at t+1.
- All idle inputs high in DRAIN at cycle n -> at n+1 the state is SLEEP, `core_wfi` = 1 and `wfi_ack` = 1. `wfi_ack` is 0 at n+2.
- Minimum latency from request to `core_wfi`: 2 cycles, when units are already idle at t+1.
- Wake seen in SLEEP at cycle m:
  - `core_wfi` = 0 at m+1.
  - WAKE occupies cycles m+1 .. m+WAKE_DLY.
  - At m+WAKE_DLY+1 the state is RUN and `wake_done` = 1.
- A wake event arriving in the same cycle that DRAIN sees all-idle -> abort wins. `core_wfi` is never asserted.
- Timeout: DRAIN entered at t+1 and never idle -> `wfi_abort` and RUN at t+1+DRAIN_TMO.
- The `wfi_abort`, `wfi_ack` and `wake_done` pulses are mutually exclusive, and each lasts exactly one cycle.
- Reset asserted mid-sleep -> `core_wfi` drops asynchronously. No `wake_done` is generated.
- `sleep_cycles` at 0xFFFF in SLEEP -> it holds at 0xFFFF.

## Structure
- Package `e203_lp_pkg`:
  - `lp_state_e` enum (2-bit, encodings as above).
  - Drain counter width of 8 and wake counter width of 4.
- Sub-module `e203_lp_satcnt`: 16-bit saturating counter with inputs `inc` and `clr`, where `clr` has priority. Used for `sleep_cycles`.
- State, counters and outputs all use async-reset flops.

## Test plan
- Request with idle units:
  - Stimulus: `wfi_req` = 1 at cycle 10 with all idle inputs = 1.
  - Response: DRAIN at 11. `core_wfi` and `wfi_ack` = 1 at 12. `wfi_ack` = 0 at 13.
- Wake and settle (WAKE_DLY = 2):
  - Stimulus: in SLEEP, `wake_evt` pulse at cycle 20.
  - Response: `core_wfi` = 0 at 21, WAKE during 21–22, `wake_done` = 1 and RUN at 23. `sleep_cycles` equals the SLEEP duration.
- Drain timeout:
  - Stimulus: `DRAIN_TMO` = 4 and `lsu_idle` held at 0.
  - Response: DRAIN cycles 1–4, then `wfi_abort` = 1 and RUN at cycle 5 (request at cycle 0). `core_wfi` never asserts.
- Simultaneous idle and wake:
  - Stimulus: in DRAIN, all idle inputs and `wake_evt` asserted in the same cycle.
  - Response: `wfi_abort` = 1, RUN next cycle, `core_wfi` stays 0.
- Request blocked by debug:
  - Stimulus: `dbg_mode` = 1 with `wfi_req` = 1 in RUN.
  - Response: `wfi_abort` pulse every cycle the request is held; the state stays RUN.
- Counter saturation, clear, and reset:
  - Force `sleep_cycles` to 0xFFFE and stay in SLEEP for 3 cycles -> it reads 0xFFFF.
  - Assert `sleep_cnt_clr` during SLEEP -> 0 next cycle.
  - Assert `rst_n` low mid-SLEEP -> all outputs 0 immediately.
